// File: rtl/pwm_multi_if.sv
// Duty-write and PWM output bundle for pwm_multi.
// master: the block that writes duties and observes the outputs.
// slave:  the PWM generator itself.
interface pwm_multi_if #(
    parameter int CH  = 4,
    parameter int CW  = 10,
    parameter int CHW = 2
);
    logic           en;
    logic           duty_we;
    logic [CHW-1:0] duty_ch;
    logic [CW-1:0]  duty_val;
    logic [CH-1:0]  pwm_out;
    logic           period_start;

    modport master (
        output en, duty_we, duty_ch, duty_val,
        input  pwm_out, period_start
    );

    modport slave (
        input  en, duty_we, duty_ch, duty_val,
        output pwm_out, period_start
    );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with one shared period counter and
// double-buffered per-channel duty registers (shadow -> act at period end).
// Optional macro PWM_CENTER_EN turns the counter into an up/down triangle
// for centre-aligned pulses; without it the output is edge-aligned.
//
// Direction register (PWM_CENTER_EN only):
//   state  | meaning
//   DIR_UP | counter ramping 0 -> PERIOD-1
//   DIR_DN | counter ramping PERIOD-1 -> 0, reload at the valley
module pwm_multi #(
    parameter int CH     = 4,
    parameter int PERIOD = 512,
    parameter int CW     = 10,
    parameter int CHW    = 2
) (
    input  logic      clk_main,
    input  logic      rst_n,
    pwm_multi_if.slave bus
);
    localparam logic [CW-1:0] PER_V  = CW'(PERIOD);
    localparam logic [CW-1:0] LAST_V = CW'(PERIOD - 1);
    localparam logic [CHW:0]  CH_V   = (CHW + 1)'(CH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] shadow     [CH];
    logic [CW-1:0] shadow_nxt [CH];
    logic [CW-1:0] act        [CH];
    logic [CH-1:0] cmp;
    logic [CH-1:0] pwm_q;
    logic          ps_q;
    logic          wr_ok;
    logic [CW-1:0] wr_val;
    logic          reload;
    logic          at_start;

    // Clamp the incoming duty and build the post-write shadow view; this
    // same view feeds the reload so a write on the wrap edge is forwarded.
    always_comb begin
        wr_ok  = bus.duty_we && ({1'b0, bus.duty_ch} < CH_V);
        wr_val = (bus.duty_val > PER_V) ? PER_V : bus.duty_val;
        for (int i = 0; i < CH; i++) begin
            shadow_nxt[i] = (wr_ok && (bus.duty_ch == CHW'(i))) ? wr_val : shadow[i];
        end
    end

    // Per-channel compare against the duty latched for this period.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < CH; i++) begin
            cmp[i] = (cnt < act[i]);
        end
    end

`ifdef PWM_CENTER_EN
    typedef enum logic {DIR_UP, DIR_DN} dir_t;
    dir_t dir, dir_nxt;

    // Triangle counter: both ends are held for two cycles (turnaround),
    // reload happens at the valley on the way down.
    always_comb begin
        cnt_nxt  = cnt;
        dir_nxt  = dir;
        reload   = 1'b0;
        at_start = (cnt == '0) && (dir == DIR_UP);
        case (dir)
            DIR_UP: begin
                if (cnt == LAST_V) dir_nxt = DIR_DN;
                else               cnt_nxt = cnt + 1'b1;
            end
            DIR_DN: begin
                if (cnt == '0) begin
                    dir_nxt = DIR_UP;
                    reload  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: dir_nxt = DIR_UP;
        endcase
    end

    // Direction register; disable parks it on the up ramp.
    always_ff @(posedge clk_main) begin
        if (!rst_n || !bus.en) dir <= DIR_UP;
        else                   dir <= dir_nxt;
    end
`else
    // Edge-aligned sawtooth: wrap and reload on the last count.
    always_comb begin
        reload   = (cnt == LAST_V);
        cnt_nxt  = reload ? '0 : cnt + 1'b1;
        at_start = (cnt == '0);
    end
`endif

    // Counter, duty registers and registered outputs.
    always_ff @(posedge clk_main) begin
        if (!rst_n) begin
            cnt   <= '0;
            pwm_q <= '0;
            ps_q  <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= '0;
                act[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                shadow[i] <= shadow_nxt[i];
            end
            if (!bus.en) begin
                cnt   <= '0;
                pwm_q <= '0;
                ps_q  <= 1'b0;
                for (int i = 0; i < CH; i++) begin
                    act[i] <= shadow_nxt[i];
                end
            end else begin
                cnt   <= cnt_nxt;
                pwm_q <= cmp;
                ps_q  <= at_start;
                if (reload) begin
                    for (int i = 0; i < CH; i++) begin
                        act[i] <= shadow_nxt[i];
                    end
                end
            end
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = ps_q;
endmodule
